// File: rtl/reset_sequencer.sv
// reset_sequencer: qualifies asynchronous lock/ready flags and releases a bank
// of active-high resets one at a time, in index order, once the inputs have
// stayed good for a debounce window.
//
// Optional feature: define RST_SEQ_TIMEOUT_EN to add a WAIT_LOCK timeout that
// pulses pll_rst_req to the upstream PLL/MMCM. Without it pll_rst_req is 0.
//
// Ports:
//   clk             in   single rising-edge clock
//   rst             in   asynchronous active-high reset
//   lock_in         in   [NUM_LOCK] asynchronous lock flags
//   ready_in        in   asynchronous system-ready flag
//   rst_out         out  [NUM_RST] sequenced resets, bit 0 released first
//   all_released    out  high while in RUN (all resets released)
//   pll_rst_req     out  reset request pulse to the upstream PLL/MMCM
//   lock_loss_count out  [16] saturating count of qualify losses after release began
//   state           out  [3] FSM state: 0 WAIT_LOCK, 1 DEBOUNCE, 2 RELEASE, 3 RUN, 4 PLL_RST
module reset_sequencer #(
    parameter int unsigned NUM_RST         = 2,
    parameter int unsigned NUM_LOCK        = 1,
    parameter int unsigned SYNC_STAGES     = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 1024,
    parameter int unsigned STAGGER_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 125000000,
    parameter int unsigned PLL_RST_CYCLES  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_LOCK-1:0] lock_in,
    input  logic                ready_in,
    output logic [NUM_RST-1:0]  rst_out,
    output logic                all_released,
    output logic                pll_rst_req,
    output logic [15:0]         lock_loss_count,
    output logic [2:0]          state
);

    localparam int unsigned SYNC_W = NUM_LOCK + 1;
    localparam int unsigned DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned STG_W  = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
    localparam int unsigned IDX_W  = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;
`ifdef RST_SEQ_TIMEOUT_EN
    localparam int unsigned TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned PLL_W  = (PLL_RST_CYCLES > 1) ? $clog2(PLL_RST_CYCLES) : 1;
`endif

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_DEBOUNCE  = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3
`ifdef RST_SEQ_TIMEOUT_EN
        , ST_PLL_RST = 3'd4
`endif
    } state_e;

    state_e                         state_q, state_d;
    logic [SYNC_STAGES-1:0][SYNC_W-1:0] sync_q;
    logic [DEB_W-1:0]               deb_cnt_q, deb_cnt_d;
    logic [STG_W-1:0]               stg_cnt_q, stg_cnt_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [NUM_RST-1:0]             rst_out_q, rst_out_d;
    logic                           all_rel_q, all_rel_d;
    logic [15:0]                    loss_q, loss_d;
    logic                           qualify;
`ifdef RST_SEQ_TIMEOUT_EN
    logic [TO_W-1:0]                to_cnt_q, to_cnt_d;
    logic [PLL_W-1:0]               pll_cnt_q, pll_cnt_d;
    logic                           pll_req_q, pll_req_d;
`endif

    // Per-bit synchronisers; stage 0 captures {ready_in, lock_in}.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], {ready_in, lock_in}};
        end
    end

    assign qualify = &sync_q[SYNC_STAGES-1];

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_WAIT_LOCK;
            deb_cnt_q <= '0;
            stg_cnt_q <= '0;
            idx_q     <= '0;
            rst_out_q <= '1;
            all_rel_q <= 1'b0;
            loss_q    <= '0;
`ifdef RST_SEQ_TIMEOUT_EN
            to_cnt_q  <= '0;
            pll_cnt_q <= '0;
            pll_req_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
            stg_cnt_q <= stg_cnt_d;
            idx_q     <= idx_d;
            rst_out_q <= rst_out_d;
            all_rel_q <= all_rel_d;
            loss_q    <= loss_d;
`ifdef RST_SEQ_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
            pll_cnt_q <= pll_cnt_d;
            pll_req_q <= pll_req_d;
`endif
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        stg_cnt_d = stg_cnt_q;
        idx_d     = idx_q;
        rst_out_d = rst_out_q;
        loss_d    = loss_q;
`ifdef RST_SEQ_TIMEOUT_EN
        // Timeout counter only survives while waiting for lock.
        to_cnt_d  = '0;
        pll_cnt_d = '0;
`endif

        case (state_q)
            ST_WAIT_LOCK: begin
                rst_out_d = '1;
                if (qualify) begin
                    state_d   = ST_DEBOUNCE;
                    deb_cnt_d = '0;
                end
`ifdef RST_SEQ_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_PLL_RST;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
`endif
            end

            ST_DEBOUNCE: begin
                if (!qualify) begin
                    state_d = ST_WAIT_LOCK;
                end else if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_d   = ST_RELEASE;
                    idx_d     = '0;
                    stg_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end

            ST_RELEASE: begin
                if (!qualify) begin
                    state_d   = ST_WAIT_LOCK;
                    rst_out_d = '1;
                    if (loss_q != 16'hFFFF) loss_d = loss_q + 16'd1;
                end else if (stg_cnt_q == STG_W'(STAGGER_CYCLES - 1)) begin
                    rst_out_d[idx_q] = 1'b0;
                    stg_cnt_d        = '0;
                    if (idx_q == IDX_W'(NUM_RST - 1)) begin
                        state_d = ST_RUN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    stg_cnt_d = stg_cnt_q + STG_W'(1);
                end
            end

            ST_RUN: begin
                if (!qualify) begin
                    state_d   = ST_WAIT_LOCK;
                    rst_out_d = '1;
                    if (loss_q != 16'hFFFF) loss_d = loss_q + 16'd1;
                end
            end

`ifdef RST_SEQ_TIMEOUT_EN
            // qualify is deliberately ignored while the PLL is being reset.
            ST_PLL_RST: begin
                rst_out_d = '1;
                if (pll_cnt_q == PLL_W'(PLL_RST_CYCLES - 1)) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    pll_cnt_d = pll_cnt_q + PLL_W'(1);
                end
            end
`endif

            default: begin
                state_d   = ST_WAIT_LOCK;
                rst_out_d = '1;
            end
        endcase

        all_rel_d = (state_d == ST_RUN);
`ifdef RST_SEQ_TIMEOUT_EN
        pll_req_d = (state_d == ST_PLL_RST);
`endif
    end

    assign rst_out         = rst_out_q;
    assign all_released    = all_rel_q;
    assign lock_loss_count = loss_q;
    assign state           = state_q;
`ifdef RST_SEQ_TIMEOUT_EN
    assign pll_rst_req     = pll_req_q;
`else
    assign pll_rst_req     = 1'b0;
`endif

endmodule
